// File: rtl/multiplicador.sv
// Scale price calculator: weight (g) times price (cents/kg), shown as euros and cents.
// Sequential shift-add multiply, then divide by 1000 and by 100 (restoring).
module multiplicador (
    input  logic       clk,
    input  logic       rst,
    input  logic [11:0] weightInGrams,
    input  logic [9:0] centimos,
    output logic [9:0] preco,
    output logic [9:0] precofr,
    output logic       valid
);

    typedef enum logic [2:0] {
        LOAD,
        MUL,
        DIV,
        SPLIT,
        UPDATE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [21:0] mcand;
    logic [11:0] mplier;
    logic [21:0] acc;
    logic [9:0]  rem;
    logic [6:0]  rem2;

    logic [10:0] trial;
    logic        ge;
    logic [9:0]  diff;
    logic [7:0]  trial2;
    logic        ge2;
    logic [6:0]  diff2;

    // acc is the product, then the /1000 quotient, then the /100 quotient
    always_comb begin
        trial  = {rem, acc[21]};
        ge     = (trial >= 11'd1000);
        diff   = 10'(trial - 11'd1000);
        trial2 = {rem2, acc[12]};
        ge2    = (trial2 >= 8'd100);
        diff2  = 7'(trial2 - 8'd100);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:   state_nx = MUL;
            MUL:    if (cnt == 5'd11) state_nx = DIV;
            DIV:    if (cnt == 5'd21) state_nx = SPLIT;
            SPLIT:  if (cnt == 5'd12) state_nx = UPDATE;
            UPDATE: state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            rem     <= '0;
            rem2    <= '0;
            preco   <= '0;
            precofr <= '0;
            valid   <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    mcand  <= {12'd0, centimos};
                    mplier <= weightInGrams;
                    acc    <= '0;
                    rem    <= '0;
                    rem2   <= '0;
                    cnt    <= '0;
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= {mcand[20:0], 1'b0};
                    mplier <= {1'b0, mplier[11:1]};
                    cnt    <= (cnt == 5'd11) ? 5'd0 : cnt + 5'd1;
                end
                DIV: begin
                    rem <= ge ? diff : trial[9:0];
                    acc <= {acc[20:0], ge};
                    cnt <= (cnt == 5'd21) ? 5'd0 : cnt + 5'd1;
                end
                SPLIT: begin
                    rem2       <= ge2 ? diff2 : trial2[6:0];
                    acc[12:0]  <= {acc[11:0], ge2};
                    cnt        <= (cnt == 5'd12) ? 5'd0 : cnt + 5'd1;
                end
                UPDATE: begin
                    preco   <= acc[9:0];
                    precofr <= {3'd0, rem2};
                    valid   <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador: latency, truncation, input sampling, reset.
module tb_multiplicador;

    logic        clk;
    logic        rst;
    logic [11:0] weightInGrams;
    logic [9:0]  centimos;
    logic [9:0]  preco;
    logic [9:0]  precofr;
    logic        valid;

    int tests;
    int fails;

    multiplicador dut (
        .clk(clk),
        .rst(rst),
        .weightInGrams(weightInGrams),
        .centimos(centimos),
        .preco(preco),
        .precofr(precofr),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input int p, input int f,
                          input int v);
        check({tag, ".preco"}, int'(preco), p);
        check({tag, ".precofr"}, int'(precofr), f);
        check({tag, ".valid"}, int'(valid), v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        weightInGrams = 12'd1500;
        centimos = 10'd470;
        edges(2);
        check3("reset", 0, 0, 0);

        // first result appears exactly on edge 49 after release
        rst = 1'b0;
        edges(48);
        check3("edge48", 0, 0, 0);
        edges(1);
        check3("1500x470", 7, 5, 1);

        weightInGrams = 12'd4095;
        centimos = 10'd1023;
        edges(48);
        check3("hold75", 7, 5, 1);
        edges(1);
        check3("4095x1023", 41, 89, 1);

        weightInGrams = 12'd999;
        centimos = 10'd1;
        edges(49);
        check3("999x1", 0, 0, 1);

        weightInGrams = 12'd1000;
        centimos = 10'd199;
        edges(49);
        check3("1000x199", 1, 99, 1);

        weightInGrams = 12'd0;
        centimos = 10'd1023;
        edges(49);
        check3("0x1023", 0, 0, 1);

        // inputs change mid-iteration: only the next LOAD sees them
        weightInGrams = 12'd1500;
        centimos = 10'd470;
        edges(10);
        weightInGrams = 12'd1000;
        centimos = 10'd199;
        edges(39);
        check3("midchg", 7, 5, 1);
        edges(24);
        check3("midhold", 7, 5, 1);
        edges(25);
        check3("nextiter", 1, 99, 1);

        // reset lands in DIV and discards the partial result
        weightInGrams = 12'd1500;
        centimos = 10'd470;
        edges(20);
        rst = 1'b1;
        edges(1);
        check3("rstdiv", 0, 0, 0);
        rst = 1'b0;
        edges(48);
        check3("postrst48", 0, 0, 0);
        edges(1);
        check3("postrst", 7, 5, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
